// File: rtl/piso_serializer_if.sv
// Bundle of the load handshake and serial-side signals of piso_serializer.
//   load_valid / load_ready / load_data : upstream word handshake
//   ser_out / ser_valid                 : serial bit stream to the sequence detector
//   word_done                           : high during the last bit of each word
//   busy                                : serializer is shifting or in its idle gap
// Modports: master = word producer / stream consumer, slave = the serializer.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  word_done,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output ser_out,
    output ser_valid,
    output word_done,
    output busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage feeding a serial sequence detector.
// Takes WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock,
// MSB or LSB first, optionally followed by GAP idle cycles so the detector sees 0s between frames.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of piso_serializer_if (handshake in, serial stream out)
// All serial outputs are decoded from registered state only, so they are glitch-free.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam bit              HasGap  = (GAP != 0);
  // Unused when GAP==0 because the gap state is then unreachable.
  localparam logic [3:0]      GapLast = HasGap ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        gap_q, gap_d;

  logic              last_bit;
  logic              load_ready;
  logic              accept;
  logic [WIDTH-1:0]  shifted;

  assign last_bit = (state_q == StShift) && (cnt_q == CntLast);

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  // Mid-word ready only on the last bit and only without a gap, giving bubble-free streaming.
  assign load_ready = rst && ((state_q == StIdle) || (last_bit && !HasGap));
  assign accept     = bus.load_valid && load_ready;

  assign shifted = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          shift_d = bus.load_data;
          cnt_d   = '0;
        end
      end
      StShift: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          cnt_d = '0;
          if (accept) begin
            shift_d = bus.load_data;
          end else if (HasGap) begin
            state_d = StGap;
            gap_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GapLast) begin
          state_d = StIdle;
          gap_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_valid  = (state_q == StShift);
  assign bus.ser_out    = (state_q == StShift) &&
                          (MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0]);
  assign bus.word_done  = last_bit;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three instances (MSB-first, LSB-first, MSB-first with
// a 2-cycle gap) share clock and reset. Expected serial bits are queued when a word is offered
// and popped whenever an instance shows ser_valid.
module tb_piso_serializer;

  logic clk;
  logic rst;

  piso_serializer_if #(.WIDTH(4)) if0 ();
  piso_serializer_if #(.WIDTH(4)) if1 ();
  piso_serializer_if #(.WIDTH(4)) if2 ();

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) u_d0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(0)) u_d1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );
  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(2)) u_d2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Each entry: {expected bit, expected word_done}.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input int k, input logic b, input logic done);
    case (k)
      0:       q0.push_back({b, done});
      1:       q1.push_back({b, done});
      default: q2.push_back({b, done});
    endcase
  endtask

  task automatic push_word(input int k, input logic [3:0] w, input logic msb);
    for (int i = 0; i < 4; i++) begin
      push_bit(k, msb ? w[3-i] : w[i], (i == 3));
    end
  endtask

  task automatic mon(input int k, input logic sv, input logic so, input logic wd);
    logic [1:0] e;
    int         n;
    e = 2'b00;
    if (sv) begin
      case (k)
        0:       begin n = q0.size(); if (n != 0) e = q0.pop_front(); end
        1:       begin n = q1.size(); if (n != 0) e = q1.pop_front(); end
        default: begin n = q2.size(); if (n != 0) e = q2.pop_front(); end
      endcase
      chk($sformatf("d%0d_unexpected_bit", k), (n != 0), 1);
      if (n != 0) begin
        chk($sformatf("d%0d_ser_out", k), so, e[1]);
        chk($sformatf("d%0d_word_done", k), wd, e[0]);
      end
    end else begin
      chk($sformatf("d%0d_idle_ser_out", k), so, 0);
      chk($sformatf("d%0d_idle_word_done", k), wd, 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mon(0, if0.ser_valid, if0.ser_out, if0.word_done);
    mon(1, if1.ser_valid, if1.ser_out, if1.word_done);
    mon(2, if2.ser_valid, if2.ser_out, if2.word_done);
  endtask

  initial begin
    rst = 1'b0;
    if0.load_valid = 1'b0; if0.load_data = '0;
    if1.load_valid = 1'b0; if1.load_data = '0;
    if2.load_valid = 1'b0; if2.load_data = '0;

    // Reset state
    step();
    step();
    chk("rst_ready0", if0.load_ready, 0);
    chk("rst_ready2", if2.load_ready, 0);
    chk("rst_valid0", if0.ser_valid, 0);
    chk("rst_busy0", if0.busy, 0);
    rst = 1'b1;
    #1;
    chk("rel_ready0", if0.load_ready, 1);
    chk("rel_ready1", if1.load_ready, 1);
    chk("rel_ready2", if2.load_ready, 1);

    // Single word 1011, MSB-first on d0 and LSB-first on d1
    if0.load_valid = 1'b1; if0.load_data = 4'b1011;
    if1.load_valid = 1'b1; if1.load_data = 4'b1011;
    push_word(0, 4'b1011, 1'b1);
    push_word(1, 4'b1011, 1'b0);
    step();
    if0.load_valid = 1'b0;
    if1.load_valid = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      if (s > 1) step();
      chk($sformatf("t1_valid_s%0d", s), if0.ser_valid, 1);
      chk($sformatf("t1_busy_s%0d", s), if0.busy, 1);
      chk($sformatf("t1_ready_s%0d", s), if0.load_ready, (s == 4));
    end
    step();
    chk("t1_end_valid", if0.ser_valid, 0);
    chk("t1_end_busy", if0.busy, 0);
    chk("t2_end_busy", if1.busy, 0);

    // Back-to-back words 1100 then 0011 with no bubble
    if0.load_valid = 1'b1; if0.load_data = 4'b1100;
    chk("t3_ready_s0", if0.load_ready, 1);
    push_word(0, 4'b1100, 1'b1);
    step();
    if0.load_data = 4'b0011;
    for (int s = 1; s <= 8; s++) begin
      if (s > 1) step();
      if (s == 5) if0.load_valid = 1'b0;
      chk($sformatf("t3_valid_s%0d", s), if0.ser_valid, 1);
      chk($sformatf("t3_ready_s%0d", s), if0.load_ready, (s == 4 || s == 8));
      if (s == 4) push_word(0, 4'b0011, 1'b1);
    end
    step();
    chk("t3_end_valid", if0.ser_valid, 0);
    chk("t3_end_busy", if0.busy, 0);

    // GAP=2: load_valid held high, second word only taken after gap + idle cycle
    if2.load_valid = 1'b1; if2.load_data = 4'b1011;
    push_word(2, 4'b1011, 1'b1);
    step();
    if2.load_data = 4'b0110;
    for (int s = 1; s <= 7; s++) begin
      if (s > 1) step();
      chk($sformatf("t4_valid_s%0d", s), if2.ser_valid, (s <= 4));
      chk($sformatf("t4_ready_s%0d", s), if2.load_ready, (s == 7));
      chk($sformatf("t4_busy_s%0d", s), if2.busy, (s <= 6));
      if (s == 7) push_word(2, 4'b0110, 1'b1);
    end
    step();
    if2.load_valid = 1'b0;
    for (int s = 8; s <= 14; s++) begin
      if (s > 8) step();
      chk($sformatf("t4_valid_s%0d", s), if2.ser_valid, (s <= 11));
      chk($sformatf("t4_busy_s%0d", s), if2.busy, (s <= 13));
    end

    // Reset asserted during the 2nd bit of 1111 aborts the word
    if0.load_valid = 1'b1; if0.load_data = 4'b1111;
    push_bit(0, 1'b1, 1'b0);
    push_bit(0, 1'b1, 1'b0);
    step();
    if0.load_valid = 1'b0;
    step();
    chk("t5_mid_valid", if0.ser_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_out", if0.ser_out, 0);
    chk("t5_async_valid", if0.ser_valid, 0);
    chk("t5_async_busy", if0.busy, 0);
    chk("t5_async_ready", if0.load_ready, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rel_ready", if0.load_ready, 1);
    chk("t5_rel_valid", if0.ser_valid, 0);
    if0.load_valid = 1'b1; if0.load_data = 4'b1001;
    push_word(0, 4'b1001, 1'b1);
    step();
    if0.load_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("t5_end_busy", if0.busy, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
